axi_lite_ram_bridge: RTL

- AXI4-Lite slave that sits directly upstream of the DPI-backed RAM controller in the npc simulation harness.
- Accepts read and write transactions from the core's memory master and converts them into the controller's flat interface: ram_raddr/ram_rdata, ram_waddr/ram_wdata/ram_wmask/ram_wen.
- Serialises reads and writes with an alternating-priority arbiter and range-checks addresses.
- Answers out-of-range accesses itself with SLVERR, without touching RAM.

---
 rtl/axi_lite_ram_bridge.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/axi_lite_ram_bridge.sv
// AXI4-Lite slave in front of the flat-interface simulation RAM: serialises
// reads and writes with an alternating-priority arbiter and decodes the address window.
module axi_lite_ram_bridge #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter logic [ADDR_W-1:0] BASE = 64'h8000_0000,
  parameter logic [ADDR_W-1:0] SIZE = 64'h0800_0000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                bvalid,
  input  logic                bready,
  output logic [1:0]          bresp,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ADDR_W-1:0]   araddr,
  output logic                rvalid,
  input  logic                rready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic [ADDR_W-1:0]   ram_raddr,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [ADDR_W-1:0]   ram_waddr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W-1:0]   ram_wmask,
  output logic                ram_wen
);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LIMIT = BASE + SIZE;
  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(7);

  typedef enum logic [2:0] {IDLE, WR_COLLECT, WR_EXEC, WR_RESP, RD_ADDR, RD_RESP} state_t;

  state_t              state;
  logic                alive;
  logic                prio_write;
  logic                aw_held;
  logic                w_held;
  logic                wr_err;
  logic                rd_err;
  logic [ADDR_W-1:0]   aw_addr_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [STRB_W-1:0]   w_strb_q;

  logic                idle;
  logic                wr_req;
  logic                ar_hs;
  logic                aw_hs;
  logic                w_hs;
  logic                aw_now;
  logic                w_now;
  logic [ADDR_W-1:0]   aw_addr_n;
  logic [DATA_W-1:0]   w_data_n;
  logic [STRB_W-1:0]   w_strb_n;
  logic [DATA_W-1:0]   wmask_n;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >= BASE) && (a < LIMIT);
  endfunction

  // alive keeps the readies low while reset is (or was just) asserted
  assign idle    = alive && (state == IDLE);
  assign wr_req  = awvalid | wvalid;
  assign arready = idle && !(wr_req && prio_write);
  assign ar_hs   = arvalid && arready;
  assign awready = (idle && !ar_hs) || (state == WR_COLLECT && !aw_held);
  assign wready  = (idle && !ar_hs) || (state == WR_COLLECT && !w_held);
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  assign aw_now    = aw_held | aw_hs;
  assign w_now     = w_held | w_hs;
  assign aw_addr_n = aw_hs ? awaddr : aw_addr_q;
  assign w_data_n  = w_hs ? wdata : w_data_q;
  assign w_strb_n  = w_hs ? wstrb : w_strb_q;

  generate
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_mask
      assign wmask_n[gi*8 +: 8] = {8{w_strb_n[gi]}};
    end
  endgenerate

  // The RAM output is passed straight through; the held ram_raddr keeps it stable.
  assign rdata = (state == RD_RESP && !rd_err) ? ram_rdata : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      alive      <= 1'b0;
      prio_write <= 1'b0;
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      wr_err     <= 1'b0;
      rd_err     <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid     <= 1'b0;
      bresp      <= 2'b00;
      rvalid     <= 1'b0;
      rresp      <= 2'b00;
      ram_raddr  <= '0;
      ram_waddr  <= '0;
      ram_wdata  <= '0;
      ram_wmask  <= '0;
      ram_wen    <= 1'b0;
    end else begin
      alive   <= 1'b1;
      ram_wen <= 1'b0;
      case (state)
        IDLE, WR_COLLECT: begin
          if (ar_hs) begin
            state      <= RD_ADDR;
            prio_write <= 1'b1;
            rd_err     <= !in_range(araddr);
            if (in_range(araddr)) ram_raddr <= araddr & ALIGN;
          end else if (aw_hs || w_hs) begin
            aw_addr_q <= aw_addr_n;
            w_data_q  <= w_data_n;
            w_strb_q  <= w_strb_n;
            if (state == IDLE) prio_write <= 1'b0;
            if (aw_now && w_now) begin
              state   <= WR_EXEC;
              aw_held <= 1'b0;
              w_held  <= 1'b0;
              wr_err  <= !in_range(aw_addr_n);
              if (in_range(aw_addr_n)) begin
                ram_wen   <= 1'b1;
                ram_waddr <= aw_addr_n & ALIGN;
                ram_wdata <= w_data_n;
                ram_wmask <= wmask_n;
              end
            end else begin
              state   <= WR_COLLECT;
              aw_held <= aw_now;
              w_held  <= w_now;
            end
          end
        end
        WR_EXEC: begin
          state  <= WR_RESP;
          bvalid <= 1'b1;
          bresp  <= wr_err ? 2'b10 : 2'b00;
        end
        WR_RESP: begin
          if (bready) begin
            state  <= IDLE;
            bvalid <= 1'b0;
            bresp  <= 2'b00;
          end
        end
        RD_ADDR: begin
          state  <= RD_RESP;
          rvalid <= 1'b1;
          rresp  <= rd_err ? 2'b10 : 2'b00;
        end
        RD_RESP: begin
          if (rready) begin
            state  <= IDLE;
            rvalid <= 1'b0;
            rresp  <= 2'b00;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
